// File: rtl/stack_ctrl.sv
// Shared hardware stack: two requesters (A = instruction path, B = interrupt/call unit)
// take turns through a round-robin arbiter, one single-word push or pop at a time.
module stack_ctrl #(
   parameter int DATA_W     = 8,
   parameter int DEPTH_LOG2 = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  a_req,
   input  logic                  a_op,
   input  logic [DATA_W-1:0]     a_wdata,
   output logic                  a_gnt,
   output logic                  a_done,
   output logic [DATA_W-1:0]     a_rdata,
   output logic                  a_err,
   input  logic                  b_req,
   input  logic                  b_op,
   input  logic [DATA_W-1:0]     b_wdata,
   output logic                  b_gnt,
   output logic                  b_done,
   output logic [DATA_W-1:0]     b_rdata,
   output logic                  b_err,
   input  logic                  flush,
   input  logic                  clr_status,
   output logic [DEPTH_LOG2-1:0] sp,
   output logic [DEPTH_LOG2:0]   count,
   output logic                  full,
   output logic                  empty,
   output logic                  ovf_sticky,
   output logic                  unf_sticky,
   output logic [1:0]            state_dbg
);

   localparam int DEPTH = 2 ** DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] COUNT_MAX = {1'b1, {DEPTH_LOG2{1'b0}}};

   // Handshake: a requester raises x_req with x_op/x_wdata stable and keeps them
   // stable until x_done; x_gnt covers the ACCESS and DONE cycles, x_done is a
   // one-cycle strobe in DONE, and x_rdata/x_err are valid while x_done is high.
   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_DONE   = 2'd2
   } state_t;

   state_t                state, state_nxt;
   logic                  owner_b;
   logic                  last_b;
   logic                  grant_b;
   logic                  cur_op;
   logic [DATA_W-1:0]     cur_wdata;
   logic [DEPTH_LOG2-1:0] sp_dec;
   logic                  mem_we;
   logic [DATA_W-1:0]     mem [0:DEPTH-1];

   assign full      = (count == COUNT_MAX);
   assign empty     = (count == '0);
   assign state_dbg = state;
   assign cur_op    = owner_b ? b_op : a_op;
   assign cur_wdata = owner_b ? b_wdata : a_wdata;
   assign sp_dec    = sp - DEPTH_LOG2'(1);
   // B wins unless A also asks and B was the last one served.
   assign grant_b   = b_req && (!a_req || !last_b);
   assign mem_we    = (state == S_ACCESS) && !cur_op && !full && !rst;

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:   if (!flush && (a_req || b_req)) state_nxt = S_ACCESS;
         S_ACCESS: state_nxt = S_DONE;
         S_DONE:   state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_IDLE;
         owner_b    <= 1'b0;
         last_b     <= 1'b0;
         sp         <= '0;
         count      <= '0;
         a_gnt      <= 1'b0;
         a_done     <= 1'b0;
         a_rdata    <= '0;
         a_err      <= 1'b0;
         b_gnt      <= 1'b0;
         b_done     <= 1'b0;
         b_rdata    <= '0;
         b_err      <= 1'b0;
         ovf_sticky <= 1'b0;
         unf_sticky <= 1'b0;
      end else begin
         state <= state_nxt;
         case (state)
            S_IDLE: begin
               if (flush) begin
                  sp    <= '0;
                  count <= '0;
               end else if (a_req || b_req) begin
                  owner_b <= grant_b;
                  a_gnt   <= !grant_b;
                  b_gnt   <= grant_b;
               end
            end
            S_ACCESS: begin
               if (!cur_op) begin
                  if (full) begin
                     if (owner_b) b_err <= 1'b1;
                     else         a_err <= 1'b1;
                     ovf_sticky <= 1'b1;
                  end else begin
                     sp    <= sp + DEPTH_LOG2'(1);
                     count <= count + (DEPTH_LOG2+1)'(1);
                  end
               end else if (empty) begin
                  if (owner_b) begin
                     b_rdata <= '0;
                     b_err   <= 1'b1;
                  end else begin
                     a_rdata <= '0;
                     a_err   <= 1'b1;
                  end
                  unf_sticky <= 1'b1;
               end else begin
                  sp    <= sp_dec;
                  count <= count - (DEPTH_LOG2+1)'(1);
                  if (owner_b) b_rdata <= mem[sp_dec];
                  else         a_rdata <= mem[sp_dec];
               end
               if (owner_b) b_done <= 1'b1;
               else         a_done <= 1'b1;
            end
            S_DONE: begin
               a_gnt  <= 1'b0;
               a_done <= 1'b0;
               a_err  <= 1'b0;
               b_gnt  <= 1'b0;
               b_done <= 1'b0;
               b_err  <= 1'b0;
               last_b <= owner_b;
            end
            default: ;
         endcase
         // Clearing wins over a flag being set by the same transaction.
         if (clr_status) begin
            ovf_sticky <= 1'b0;
            unf_sticky <= 1'b0;
         end
      end
   end

   // Storage has no reset; a write racing an asynchronous reset is dropped.
   always_ff @(posedge clk) begin
      if (mem_we) mem[sp] <= cur_wdata;
   end

endmodule

// File: tb/tb_stack_ctrl.sv
// Bench for stack_ctrl: directed scenarios plus random two-requester traffic,
// checked every cycle against a queue-based model of the stack and arbiter.
module tb_stack_ctrl;

   localparam int DW    = 8;
   localparam int DL    = 3;
   localparam int DEPTH = 8;

   logic          clk, rst;
   logic          a_req, a_op, b_req, b_op;
   logic [DW-1:0] a_wdata, b_wdata;
   logic          a_gnt, a_done, a_err, b_gnt, b_done, b_err;
   logic [DW-1:0] a_rdata, b_rdata;
   logic          flush, clr_status;
   logic [DL-1:0] sp;
   logic [DL:0]   count;
   logic          full, empty, ovf_sticky, unf_sticky;
   logic [1:0]    state_dbg;

   int errors = 0;
   int checks = 0;
   logic rand_stop = 1'b0;

   stack_ctrl #(.DATA_W(DW), .DEPTH_LOG2(DL)) dut (
      .clk(clk), .rst(rst),
      .a_req(a_req), .a_op(a_op), .a_wdata(a_wdata), .a_gnt(a_gnt),
      .a_done(a_done), .a_rdata(a_rdata), .a_err(a_err),
      .b_req(b_req), .b_op(b_op), .b_wdata(b_wdata), .b_gnt(b_gnt),
      .b_done(b_done), .b_rdata(b_rdata), .b_err(b_err),
      .flush(flush), .clr_status(clr_status), .sp(sp), .count(count),
      .full(full), .empty(empty), .ovf_sticky(ovf_sticky),
      .unf_sticky(unf_sticky), .state_dbg(state_dbg)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   logic [DW-1:0] exp_q[$];
   int            m_phase = 0;
   logic          m_owner_b = 1'b0, m_last_b = 1'b0;
   logic          e_a_gnt = 0, e_a_done = 0, e_a_err = 0;
   logic          e_b_gnt = 0, e_b_done = 0, e_b_err = 0;
   logic [DW-1:0] e_a_rdata = '0, e_b_rdata = '0;
   logic          e_ovf = 0, e_unf = 0;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_phase = 0; m_owner_b = 0; m_last_b = 0;
         e_a_gnt = 0; e_a_done = 0; e_a_err = 0; e_a_rdata = '0;
         e_b_gnt = 0; e_b_done = 0; e_b_err = 0; e_b_rdata = '0;
         e_ovf = 0; e_unf = 0;
         exp_q.delete();
      end else begin
         if (m_phase == 0) begin
            if (flush) exp_q.delete();
            else if (a_req || b_req) begin
               m_owner_b = b_req && !(a_req && m_last_b);
               e_a_gnt = !m_owner_b;
               e_b_gnt = m_owner_b;
               m_phase = 1;
            end
         end else if (m_phase == 1) begin
            logic          op, err;
            logic [DW-1:0] d, rd;
            op  = m_owner_b ? b_op : a_op;
            d   = m_owner_b ? b_wdata : a_wdata;
            err = 0;
            rd  = m_owner_b ? e_b_rdata : e_a_rdata;
            if (!op) begin
               if (exp_q.size() == DEPTH) begin err = 1; e_ovf = 1; end
               else exp_q.push_back(d);
            end else begin
               if (exp_q.size() == 0) begin err = 1; e_unf = 1; rd = '0; end
               else rd = exp_q.pop_back();
            end
            if (m_owner_b) begin e_b_done = 1; e_b_err = err; e_b_rdata = rd; end
            else begin e_a_done = 1; e_a_err = err; e_a_rdata = rd; end
            m_phase = 2;
         end else begin
            e_a_gnt = 0; e_a_done = 0; e_a_err = 0;
            e_b_gnt = 0; e_b_done = 0; e_b_err = 0;
            m_last_b = m_owner_b;
            m_phase = 0;
         end
         if (clr_status) begin e_ovf = 0; e_unf = 0; end
      end
   end

   // ---------------- scoreboard ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: dut=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      chk("a_gnt", a_gnt, e_a_gnt);
      chk("a_done", a_done, e_a_done);
      chk("a_err", a_err, e_a_err);
      chk("a_rdata", a_rdata, e_a_rdata);
      chk("b_gnt", b_gnt, e_b_gnt);
      chk("b_done", b_done, e_b_done);
      chk("b_err", b_err, e_b_err);
      chk("b_rdata", b_rdata, e_b_rdata);
      chk("count", count, exp_q.size());
      chk("sp", sp, exp_q.size() % DEPTH);
      chk("full", full, exp_q.size() == DEPTH);
      chk("empty", empty, exp_q.size() == 0);
      chk("ovf_sticky", ovf_sticky, e_ovf);
      chk("unf_sticky", unf_sticky, e_unf);
   end

   // ---------------- driver tasks ----------------
   task automatic txn_a(input logic op, input logic [DW-1:0] d);
      int n;
      a_op = op; a_wdata = d; a_req = 1'b1; n = 0;
      do begin @(negedge clk); n++; end while (a_done !== 1'b1 && n < 40);
      chk("a_timeout", a_done, 1);
      a_req = 1'b0;
   endtask

   task automatic txn_b(input logic op, input logic [DW-1:0] d);
      int n;
      b_op = op; b_wdata = d; b_req = 1'b1; n = 0;
      do begin @(negedge clk); n++; end while (b_done !== 1'b1 && n < 40);
      chk("b_timeout", b_done, 1);
      b_req = 1'b0;
   endtask

   task automatic rand_a(input int n);
      for (int i = 0; i < n; i++) begin
         repeat ($urandom_range(0, 3)) @(negedge clk);
         txn_a(1'($urandom_range(0, 1)), 8'($urandom));
      end
   endtask

   task automatic rand_b(input int n);
      for (int i = 0; i < n; i++) begin
         repeat ($urandom_range(0, 3)) @(negedge clk);
         txn_b(1'($urandom_range(0, 1)), 8'($urandom));
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      rst = 1; a_req = 0; a_op = 0; a_wdata = '0; b_req = 0; b_op = 0; b_wdata = '0;
      flush = 0; clr_status = 0;
      repeat (2) @(negedge clk);
      chk("rst_count", count, 0);
      chk("rst_sp", sp, 0);
      chk("rst_empty", empty, 1);
      chk("rst_state", state_dbg, 0);
      rst = 0;

      // simultaneous requests: B first, then alternation
      a_op = 0; a_wdata = 8'hA1; b_op = 0; b_wdata = 8'hB1; a_req = 1; b_req = 1;
      @(negedge clk); chk("arb_c1_b_gnt", b_gnt, 1); chk("arb_c1_a_gnt", a_gnt, 0);
      @(negedge clk); chk("arb_c2_b_done", b_done, 1);
      @(negedge clk); chk("arb_c3_a_gnt", a_gnt, 0); chk("arb_c3_b_gnt", b_gnt, 0);
      @(negedge clk); chk("arb_c4_a_gnt", a_gnt, 1);
      @(negedge clk); chk("arb_c5_a_done", a_done, 1);
      repeat (2) @(negedge clk); chk("arb_c7_b_gnt", b_gnt, 1);
      repeat (3) @(negedge clk); chk("arb_c10_a_gnt", a_gnt, 1);
      @(negedge clk); chk("arb_count", count, 4);
      a_req = 0; b_req = 0;
      txn_a(1, 0); chk("arb_pop0", a_rdata, 8'hA1);
      txn_a(1, 0); chk("arb_pop1", a_rdata, 8'hB1);
      txn_a(1, 0); txn_a(1, 0);

      // LIFO order
      txn_a(0, 8'h11); txn_a(0, 8'h22); txn_a(0, 8'h33);
      chk("lifo_count3", count, 3); chk("lifo_sp3", sp, 3);
      txn_a(1, 0); chk("lifo_pop33", a_rdata, 8'h33); chk("lifo_err", a_err, 0);
      txn_a(1, 0); chk("lifo_pop22", a_rdata, 8'h22);
      txn_a(1, 0); chk("lifo_pop11", a_rdata, 8'h11); chk("lifo_count0", count, 0);

      // fill, overflow, drain
      for (int i = 0; i < DEPTH; i++) txn_a(0, 8'(8'h80 + i));
      chk("full_flag", full, 1); chk("full_sp", sp, 0);
      txn_a(0, 8'hEE);
      chk("ovf_err", a_err, 1); chk("ovf_sticky", ovf_sticky, 1); chk("ovf_count", count, 8);
      txn_a(1, 0); chk("ovf_pop_top", a_rdata, 8'h87);
      for (int i = 0; i < DEPTH - 1; i++) txn_a(1, 0);
      chk("ovf_pop_bottom", a_rdata, 8'h80);

      // underflow by B, then clear sticky
      txn_b(1, 0);
      chk("unf_err", b_err, 1); chk("unf_rdata", b_rdata, 0); chk("unf_sticky", unf_sticky, 1);
      clr_status = 1; @(negedge clk); clr_status = 0;
      chk("clr_unf", unf_sticky, 0); chk("clr_ovf", ovf_sticky, 0);

      // flush in IDLE holds off a pending request
      for (int i = 0; i < 5; i++) txn_a(0, 8'(8'h40 + i));
      flush = 1; a_op = 1; a_req = 1;
      repeat (2) @(negedge clk);
      chk("flush_count", count, 0); chk("flush_sp", sp, 0); chk("flush_gnt", a_gnt, 0);
      @(negedge clk); chk("flush_hold_gnt", a_gnt, 0);
      flush = 0;
      txn_a(1, 0); chk("flush_pop_err", a_err, 1);

      // reset in the middle of a push
      txn_a(0, 8'h01); txn_a(0, 8'h02);
      a_op = 0; a_wdata = 8'h77; a_req = 1;
      repeat (2) @(negedge clk); chk("rstmid_gnt_before", a_gnt, 1);
      #2 rst = 1;
      #1 chk("rstmid_gnt", a_gnt, 0); chk("rstmid_done", a_done, 0); chk("rstmid_count", count, 0);
      @(negedge clk); rst = 0; a_req = 0;
      repeat (3) @(negedge clk); chk("rstmid_no_done", a_done, 0);
      txn_a(0, 8'h5A); chk("rstmid_sp", sp, 1);
      txn_a(1, 0); chk("rstmid_pop", a_rdata, 8'h5A);

      // random concurrent traffic with occasional flush / clear
      fork
         begin
            fork rand_a(40); rand_b(40); join
            rand_stop = 1;
         end
         begin
            while (!rand_stop) begin
               @(negedge clk);
               clr_status = ($urandom_range(0, 19) == 0);
               flush      = ($urandom_range(0, 29) == 0);
            end
            clr_status = 0; flush = 0;
         end
      join
      repeat (4) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/stack_ctrl.md
Name: stack_ctrl

Overview:
- Owns the hardware stack (pointer, occupancy, storage) and shares it between two requesters: A = core instruction path (PUSH/POP), B = interrupt/call unit (context save/restore).
- Serialises one single-byte transaction at a time with round-robin arbitration.
- Reports overflow and underflow per transaction and as sticky status.

Parameters:
DATA_W, 8, stack word width
DEPTH_LOG2, 8, log2 of stack depth (2**DEPTH_LOG2 entries)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset
a_req  in  1  requester A transaction request; hold with a_op/a_wdata stable until a_done
a_op  in  1  0 = push, 1 = pop
a_wdata  in  DATA_W  push data
a_gnt  out  1  A owns the stack (ACCESS and DONE states)
a_done  out  1  one-cycle completion strobe
a_rdata  out  DATA_W  pop result, valid while a_done = 1, held until next A pop
a_err  out  1  transaction failed (overflow/underflow), valid with a_done
b_req, b_op, b_wdata, b_gnt, b_done, b_rdata, b_err: as for A, requester B
flush  in  1  empty the stack (sp and count to 0)
clr_status  in  1  clear sticky flags
sp  out  DEPTH_LOG2  current stack pointer (next free slot)
count  out  DEPTH_LOG2+1  occupancy, 0..2**DEPTH_LOG2
full  out  1  count == 2**DEPTH_LOG2 (combinational from count)
empty  out  1  count == 0 (combinational from count)
ovf_sticky  out  1  a push was refused since the last clear
unf_sticky  out  1  a pop was refused since the last clear

Behaviour:
- Reset (async, any state): state = IDLE; sp = 0; count = 0; all gnt/done/err = 0; rdata = 0; sticky flags = 0; last_grant = A, so B wins the first tie. Memory contents are not cleared. An in-flight transaction is abandoned with no done strobe.
- FSM states: IDLE -> ACCESS -> DONE -> IDLE. All outputs except full/empty are registered.
- IDLE:
  - If flush = 1: sp = 0, count = 0, stay IDLE; requests wait.
  - Else if any req is high: grant it. If both are high, grant the requester not granted last. Set x_gnt = 1, record the owner, go to ACCESS.
- ACCESS, owner x, at the clock edge:
  - push, not full: mem[sp] <= x_wdata; sp <= sp + 1; count <= count + 1.
  - push, full: no write, sp/count unchanged, x_err <= 1, ovf_sticky <= 1.
  - pop, not empty: sp <= sp - 1; count <= count - 1; x_rdata <= mem[sp - 1], using the pre-decrement sp.
  - pop, empty: sp/count unchanged, x_rdata <= 0, x_err <= 1, unf_sticky <= 1.
  - Always: x_done <= 1; go to DONE.
- DONE: x_gnt and x_done are high for exactly this cycle. At the edge, clear gnt/done/err, set last_grant = x, go to IDLE.
- Latency: req seen in IDLE at cycle 0 -> gnt in cycles 1-2 -> done in cycle 2 -> next arbitration in cycle 3. Throughput is one transaction per 3 cycles.
- The requester drops req in the cycle after done, or keeps it high with new op/data to queue the next transaction. A req that is still high in IDLE is treated as new.
- sp arithmetic is modulo 2**DEPTH_LOG2. At full, sp has wrapped to 0; full/empty are decided only by count, never by sp.
- flush during ACCESS/DONE is ignored. The caller holds flush until it sees both gnt low.
- clr_status has priority over setting a sticky flag in the same cycle. The sticky flag still reports this transaction via x_err.
- Non-owner gnt/done/err stay 0. Requests change nothing while another transaction is in flight.

Test Plan:
- Reset then A pushes 0x11, 0x22, 0x33, then pops three times -> a_rdata 0x33, 0x22, 0x11 on successive a_done; count 3->0; sp 3->0; a_err = 0 throughout.
- a_req and b_req raised together in the same cycle after reset -> B granted first (b_gnt cycles 1-2), A granted cycles 4-5. Both held high continuously -> grants alternate A, B, A...
- DEPTH_LOG2 = 2: push 4 values -> full = 1, sp = 0. 5th push -> a_err = 1 with a_done, ovf_sticky = 1, count stays 4, mem[0] unchanged (pop x4 returns original data).
- Pop from empty by B -> b_err = 1, b_rdata = 0x00, unf_sticky = 1. clr_status pulse -> unf_sticky = 0.
- flush asserted in IDLE with count 5 while a_req high -> count = 0, sp = 0, A granted only after flush drops; its pop then errors.
- rst pulsed during ACCESS of a push -> gnt/done low immediately, count = 0, no done strobe. Next push lands at sp 0.
